// File: rtl/tag_free_list_pkg.sv
// Shared definitions for the tag free list: width helpers and the default
// number of tags held back for architectural mappings after reset.
package freelist_pkg;

    localparam int RESERVED_DEFAULT = 0;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

    // Width of a tag index and of a free-count for a given number of tags.
    function automatic int tag_w(input int width);
        return clog2(width);
    endfunction

    function automatic int count_w(input int width);
        return clog2(width + 1);
    endfunction

endpackage

// File: rtl/tag_free_list_if.sv
// Allocate/return handshake between the rename/retire stages (master) and
// the tag free list (slave).
interface tag_free_list_if #(
    parameter int WIDTH = 4
);
    localparam int OUTW = freelist_pkg::tag_w(WIDTH);
    localparam int CNTW = freelist_pkg::count_w(WIDTH);

    logic            alloc_req;
    logic            alloc_valid;
    logic [OUTW-1:0] alloc_tag;
    logic            free_valid;
    logic [OUTW-1:0] free_tag;
    logic [CNTW-1:0] free_count;
    logic            err;

    modport master (
        output alloc_req, free_valid, free_tag,
        input  alloc_valid, alloc_tag, free_count, err
    );

    modport slave (
        input  alloc_req, free_valid, free_tag,
        output alloc_valid, alloc_tag, free_count, err
    );

endinterface

// File: rtl/tag_free_list_prioritydecoder.sv
// Highest-set-bit priority decoder: out is the index of the highest set bit
// of in, valid is high when any bit is set; out is 0 when nothing is set.
module prioritydecoder #(
    parameter int WIDTH = 4,
    parameter int OUTW  = freelist_pkg::clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] in,
    output logic [OUTW-1:0]  out,
    output logic             valid
);

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    always_comb begin
        out   = '0;
        valid = 1'b0;
        // Ascending scan so the highest set bit is the last one written.
        for (int i = 0; i < WIDTH; i++) begin
            if (in[i]) begin
                out   = OUTW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tag_free_list.sv
// Free bitmap of WIDTH tags; offers the highest free tag and accepts returns.
// Optional double-free/out-of-range detection under `FREELIST_CHECK_EN`.
module tag_free_list
    import freelist_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int RESERVED = RESERVED_DEFAULT
) (
    input logic            clk,
    input logic            rst_n,
    tag_free_list_if.slave bus
);

    localparam int OUTW = clog2(WIDTH);
    localparam int CNTW = clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] RESET_MAP = ~((WIDTH'(1) << RESERVED) - WIDTH'(1));
    localparam logic [CNTW-1:0]  RESET_CNT = CNTW'(WIDTH - RESERVED);

    logic [WIDTH-1:0] free_map, free_map_next;
    logic [CNTW-1:0]  free_count, count_next;
    logic             alloc_fire, free_fire, free_in_range;
    logic             free_was_set, alloc_hits_free;

    prioritydecoder #(.WIDTH(WIDTH), .OUTW(OUTW)) u_dec (
        .in    (free_map),
        .out   (bus.alloc_tag),
        .valid (bus.alloc_valid)
    );

    assign alloc_fire      = bus.alloc_req && bus.alloc_valid;
    assign free_in_range   = (32'(bus.free_tag) < WIDTH);
    assign free_fire       = bus.free_valid && free_in_range;
    assign free_was_set    = free_in_range && free_map[bus.free_tag];
    assign alloc_hits_free = alloc_fire && (bus.alloc_tag == bus.free_tag);

    // Free is applied after alloc so a same-tag collision leaves the bit set;
    // the count then nets to zero because the bit was clear after the alloc.
    always_comb begin
        free_map_next = free_map;
        count_next    = free_count;
        if (alloc_fire) begin
            free_map_next[bus.alloc_tag] = 1'b0;
            count_next                   = count_next - CNTW'(1);
        end
        if (free_fire) begin
            free_map_next[bus.free_tag] = 1'b1;
            if (!free_was_set || alloc_hits_free) count_next = count_next + CNTW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_map   <= RESET_MAP;
            free_count <= RESET_CNT;
        end else begin
            free_map   <= free_map_next;
            free_count <= count_next;
        end
    end

    assign bus.free_count = free_count;

`ifdef FREELIST_CHECK_EN
    logic err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (bus.free_valid && (!free_in_range || free_was_set || alloc_hits_free)) begin
            err <= 1'b1;
        end
    end

    assign bus.err = err;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_tag_free_list.sv
// Scoreboard bench for tag_free_list: a set-based reference model predicts the
// outputs of every cycle; a monitor compares them on the falling edge.
module tb_tag_free_list;

    localparam int WIDTH = 4;
    localparam int CYCLES = 400;

    typedef struct {
        bit valid;
        int tag;
        int count;
        bit err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    tag_free_list_if #(.WIDTH(WIDTH)) bus ();

    tag_free_list #(.WIDTH(WIDTH), .RESERVED(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: the set of free tags plus the sticky error flag.
    bit   free_set[int];
    bit   m_err;

    function automatic int model_top();
        int t;
        t = -1;
        foreach (free_set[k]) if (k > t) t = k;
        return t;
    endfunction

    function automatic exp_t model_outputs();
        exp_t e;
        e.valid = (free_set.num() > 0);
        e.tag   = e.valid ? model_top() : 0;
        e.count = free_set.num();
        e.err   = m_err;
        return e;
    endfunction

    task automatic model_reset();
        free_set.delete();
        for (int i = 0; i < WIDTH; i++) free_set[i] = 1'b1;
        m_err = 1'b0;
    endtask

    task automatic model_edge(input bit req, input bit fv, input int ft);
        bit fire;
        int tag;
        fire = req && (free_set.num() > 0);
        tag  = model_top();
`ifdef FREELIST_CHECK_EN
        if (fv && (ft >= WIDTH || free_set.exists(ft) || (fire && tag == ft))) m_err = 1'b1;
`endif
        if (fire) free_set.delete(tag);
        if (fv && ft < WIDTH) free_set[ft] = 1'b1;
    endtask

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected)
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        else
            n_pass++;
    endtask

    // One cycle of stimulus: record the outputs expected for this cycle, drive
    // the inputs, then advance the model across the coming edge.
    task automatic step(input bit req, input bit fv, input int ft);
        @(posedge clk);
        #1;
        exp_q.push_back(model_outputs());
        bus.alloc_req  = req;
        bus.free_valid = fv;
        bus.free_tag   = ft[1:0];
        model_edge(req, fv, ft);
    endtask

    // Asynchronous reset in the middle of a cycle, released after two edges.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        bus.alloc_req  = 1'b0;
        bus.free_valid = 1'b0;
        bus.free_tag   = '0;
        model_reset();
        #1;
        exp_q.push_back(model_outputs());
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("alloc_valid", int'(bus.alloc_valid), int'(e.valid));
                check("alloc_tag",   int'(bus.alloc_tag),   e.tag);
                check("free_count",  int'(bus.free_count),  e.count);
                check("err",         int'(bus.err),         int'(e.err));
            end
        end
    end

    initial begin : stimulus
        int drain;
        bus.alloc_req  = 1'b0;
        bus.free_valid = 1'b0;
        bus.free_tag   = '0;
        model_reset();
        #12;
        rst_n = 1'b1;

        // Reset state, then drain all four tags; the fifth request is ignored.
        step(1'b1, 1'b0, 0);
        repeat (3) step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        // Return tag 1 from empty: not offered in the same cycle.
        step(1'b0, 1'b1, 1);
        step(1'b0, 1'b1, 3);
        // Map 1010: allocate 3 while freeing 0 -> map 0011.
        step(1'b1, 1'b1, 0);
        step(1'b0, 1'b0, 0);

        // Map 0100 then a double free of tag 2.
        do_reset();
        repeat (4) step(1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 2);
        step(1'b0, 1'b1, 2);
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 0);

        // Map 0001 with an allocation in flight, then reset mid-cycle.
        do_reset();
        repeat (4) step(1'b1, 1'b0, 0);
        step(1'b0, 1'b1, 0);
        step(1'b1, 1'b0, 0);
        do_reset();
        step(1'b0, 1'b0, 0);

        // Same-tag alloc/free collision: free wins, count unchanged.
        step(1'b1, 1'b1, 3);
        step(1'b0, 1'b0, 0);

        for (int i = 0; i < CYCLES; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            else step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                      int'($urandom_range(0, WIDTH - 1)));
        end
        step(1'b0, 1'b0, 0);

        drain = 0;
        while (exp_q.size() > 0 && drain < 10) begin
            @(negedge clk);
            drain++;
        end
        #1;
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
